// File: rtl/rx_sched_pkg.sv
// Shared definitions for the receive slot scheduler: one-hot FSM encodings and
// the ring slot address helper.
package rx_sched_pkg;

  localparam logic [2:0] ST_IDLE     = 3'b001;
  localparam logic [2:0] ST_ARM      = 3'b010;
  localparam logic [2:0] ST_WAIT_CLR = 3'b100;

  // slot_bytes is a power of two, so the stride multiply reduces to a shift.
  function automatic logic [31:0] slot_addr(input logic [31:0]  base,
                                            input logic [31:0]  idx,
                                            input int unsigned  slot_bytes);
    return {base[31:2], 2'b00} + (idx << $clog2(slot_bytes));
  endfunction

endpackage

// File: rtl/rx_slot_scheduler.sv
// Hands the Ethernet receiver one free ring slot at a time, commits it on
// completion and queues filled slots for the CPU until released.
module rx_slot_scheduler
  import rx_sched_pkg::*;
#(
  parameter int unsigned SLOTS      = 8,
  parameter int unsigned SLOT_BYTES = 2048
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [31:0]              cfg_base,
  input  logic                     cfg_enable,
  output logic [31:0]              rx_addr_offset,
  output logic                     rx_addr_ready,
  input  logic                     rx_done,
  output logic                     cpu_avail,
  output logic [31:0]              cpu_slot_addr,
  input  logic                     cpu_pop,
  output logic [$clog2(SLOTS):0]   cpu_count,
  output logic [31:0]              pkt_count,
  output logic                     irq
);

  localparam int unsigned IDX_W = $clog2(SLOTS);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [2:0]       r_state;
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] r_rd_idx;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_pkt_count;
  logic [31:0]      r_offset;
  logic             r_ready;
  logic             r_irq;
  logic             r_avail;

  logic             w_commit;
  logic             w_pop;
  logic             w_can_arm;

  assign w_commit  = (r_state == ST_ARM) && rx_done;
  assign w_pop     = cpu_pop && (r_count != '0);
  assign w_can_arm = cfg_enable && (r_count < CNT_W'(SLOTS));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_wr_idx    <= '0;
      r_offset    <= '0;
      r_ready     <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_can_arm) begin
            r_offset <= slot_addr(cfg_base, 32'(r_wr_idx), SLOT_BYTES);
            r_ready  <= 1'b1;
            r_state  <= ST_ARM;
          end
        end
        ST_ARM: begin
          // Once armed, the slot is only left through completion.
          if (rx_done) begin
            r_ready     <= 1'b0;
            r_wr_idx    <= r_wr_idx + IDX_W'(1);
            r_pkt_count <= r_pkt_count + 32'd1;
            r_state     <= ST_WAIT_CLR;
          end
        end
        ST_WAIT_CLR: begin
          if (!rx_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rd_idx <= '0;
      r_count  <= '0;
      r_irq    <= 1'b0;
      r_avail  <= 1'b0;
    end else begin
      r_irq   <= (r_count != '0);
      r_avail <= (r_count != '0);
      if (w_pop) begin
        r_rd_idx <= r_rd_idx + IDX_W'(1);
      end
      // Simultaneous commit and pop leaves the occupancy unchanged.
      unique case ({w_commit, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rx_addr_offset = r_offset;
  assign rx_addr_ready  = r_ready;
  assign cpu_avail      = r_avail;
  assign cpu_slot_addr  = slot_addr(cfg_base, 32'(r_rd_idx), SLOT_BYTES);
  assign cpu_count      = r_count;
  assign pkt_count      = r_pkt_count;
  assign irq            = r_irq;

endmodule

// File: doc/rx_slot_scheduler.md
# rx_slot_scheduler

Sequences the Ethernet receive path's Wishbone write-back into a ring of fixed-size memory slots.
- Hands the receiver one free slot address at a time through its address-ready handshake.
- Commits the slot when the receiver signals completion.
- Queues filled slots for the CPU and frees them on CPU release.
- Sits between the packet receiver (wb_clk_i domain) and the CPU register block.

## Interface
Parameters:
- SLOTS, 8: ring depth; power of two, 2..256.
- SLOT_BYTES, 2048: slot stride in bytes; power of two, ≥ 64.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cfg_base  in  32  ring base byte address; bits [1:0] ignored (treated as 0).
- cfg_enable  in  1  permits arming new slots; sampled only in IDLE.
- rx_addr_offset  out  32  start address of the armed slot, to the receiver's address-offset input.
- rx_addr_ready  out  1  slot armed; the receiver starts on its rising edge.
- rx_done  in  1  receiver completion flag; level; stays high until rx_addr_ready falls.
- cpu_avail  out  1  at least one filled slot is queued.
- cpu_slot_addr  out  32  address of the oldest filled slot.
- cpu_pop  in  1  single-cycle pulse; releases the oldest filled slot.
- cpu_count  out  $clog2(SLOTS)+1  number of filled slots.
- pkt_count  out  32  total committed slots; wraps modulo 2^32.
- irq  out  1  registered (cpu_count != 0).

## Operation
- State: wr_idx, rd_idx (each $clog2(SLOTS) bits, wrap modulo SLOTS), count, pkt_count.
- Address arithmetic: slot address = {cfg_base[31:2],2'b00} + idx·SLOT_BYTES, using a shift, 32-bit, wrapping.
- FSM states: IDLE, ARM, WAIT_CLR (one-hot).
- IDLE:
  - Condition cfg_enable && count < SLOTS.
  - On that condition: register rx_addr_offset = addr(wr_idx), set rx_addr_ready=1, go to ARM.
  - Otherwise stay in IDLE.
- ARM:
  - rx_addr_ready held at 1.
  - On rx_done=1: clear rx_addr_ready, wr_idx+1, count+1, pkt_count+1, go to WAIT_CLR.
  - cfg_enable is ignored here; an armed slot is never aborted.
- WAIT_CLR: on rx_done=0, go to IDLE.
- Pop:
  - When cpu_pop && count != 0: rd_idx+1, count-1.
  - cpu_pop with count=0 is ignored; no state change.
- Commit and pop in the same cycle: count unchanged; both indices advance.
- rx_done=1 seen in IDLE: ignored.
- rx_addr_offset holds its last value outside ARM.
- cpu_slot_addr is combinational from rd_idx and cfg_base. It is valid only while cpu_avail=1.
- Changing cfg_base while count != 0 or in ARM is undefined usage; the block does not check it.
- Reset values: state IDLE, rx_addr_ready 0, rx_addr_offset 0, indices 0, count 0, cpu_avail 0, pkt_count 0, irq 0.
- Reset mid-ARM: all slots are dropped and rx_addr_ready falls immediately. Resetting the receiver alongside is the top level's job.

## Timing
- IDLE with the arm condition true at edge N: rx_addr_ready=1 and rx_addr_offset valid after edge N.
- rx_done sampled high in ARM at edge M:
  - rx_addr_ready=0 after edge M.
  - count, cpu_count and pkt_count update after edge M.
  - irq and cpu_avail follow at edge M+1.
- rx_addr_ready stays low for at least 2 cycles between slots: WAIT_CLR needs ≥1 cycle, then IDLE takes 1 cycle. This guarantees a clean rising edge.
- cpu_pop at edge P: cpu_count updates after P; cpu_slot_addr reflects the new rd_idx after P; irq follows at P+1.
- Full ring (count=SLOTS): the block stays in IDLE with rx_addr_ready=0 until a pop. After the pop edge, the next edge arms.

## Structure
- Shared package rx_sched_pkg holds:
  - FSM state constants (ST_IDLE, ST_ARM, ST_WAIT_CLR);
  - the function slot_addr(base, idx, slot_bytes).
- The design is a single module with no sub-module.
- Index and count logic is inline.
- irq and cpu_avail are registered.

## Test plan
- Reset, cfg_base=0x0010_0000, cfg_enable=1 → rx_addr_ready high 1 cycle after reset release, rx_addr_offset=0x0010_0000. Assert rx_done → ready low next cycle, cpu_count=1, cpu_slot_addr=0x0010_0000, irq=1 one cycle later.
- Complete 8 slots without pops (SLOTS=8, SLOT_BYTES=2048) → offsets step by 0x800 up to 0x0010_3800. Then ready stays 0 and count=8. One cpu_pop → rearm at 0x0010_0000 (wrap).
- Commit and cpu_pop in the same cycle with count=3 → count stays 3; rd_idx and wr_idx both advance.
- cpu_pop with count=0 → no change; irq stays 0.
- rx_done held high 5 cycles after commit → no second commit; rearm only after rx_done falls, with ready low ≥2 cycles.
- Assert wb_rst_i asynchronously mid-ARM → all outputs at reset values before the next edge; pkt_count=0.
